// File: rtl/rs_encoder_seq_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg -- shared constants and GF(16) helpers for the RS(15,9) encoder and
// the matching decoder.
//   * Code shape: N=15, K=9, NPAR=6 parity symbols, 4-bit symbols.
//   * Field: GF(16) with primitive polynomial x^4 + x + 1 (alpha^4 = 4'h3).
//   * Generator: g(x) = (x+a^1)(x+a^2)...(x+a^6)
//              = x^6 + 7x^5 + 9x^4 + 3x^3 + Cx^2 + Ax + C
//   * gf_mul: 4x4 field multiply, result always 4 bits.
// ---------------------------------------------------------------------------
package rs_pkg;

    localparam int N     = 15;
    localparam int K     = 9;
    localparam int NPAR  = 6;
    localparam int SYM_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } enc_state_e;

    // Antilog table, alpha^e lives at [4*e +: 4] (alpha^0 in the low nibble).
    localparam logic [N*SYM_W-1:0] GF_EXP_TBL = {
        4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5, 4'hB,
        4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
    };

    // Generator coefficients g0..g5; the monic x^6 term is implicit.
    localparam logic [SYM_W-1:0] G0 = 4'hC;
    localparam logic [SYM_W-1:0] G1 = 4'hA;
    localparam logic [SYM_W-1:0] G2 = 4'hC;
    localparam logic [SYM_W-1:0] G3 = 4'h3;
    localparam logic [SYM_W-1:0] G4 = 4'h9;
    localparam logic [SYM_W-1:0] G5 = 4'h7;
    localparam logic [NPAR*SYM_W-1:0] GEN_COEF = {G5, G4, G3, G2, G1, G0};

    // Shift-and-add multiply; each doubling of 'aa' reduces by x^4 = x + 1.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[SYM_W-2:0], 1'b0} ^ (aa[SYM_W-1] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_encoder_seq_gf_mult.sv
// ---------------------------------------------------------------------------
// gf_mult -- combinational GF(16) multiplier (x^4 + x + 1).
// Ports:
//   a_i [3:0]  multiplicand
//   b_i [3:0]  multiplier
//   p_o [3:0]  product a_i * b_i in GF(16)
// ---------------------------------------------------------------------------
module gf_mult
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] a_i,
    input  logic [SYM_W-1:0] b_i,
    output logic [SYM_W-1:0] p_o
);

    assign p_o = gf_mul(a_i, b_i);

endmodule

// File: rtl/rs_encoder_seq.sv
// ---------------------------------------------------------------------------
// rs_encoder_seq -- sequential systematic RS(15,9) encoder over GF(16).
// One message symbol per clock goes through a 6-stage parity LFSR, from
// symbol 14 down to symbol 6.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   encodeMessage  start request, only looked at in IDLE
//   messageIn[35:0]    nine message symbols, [4*j +: 4] = codeword symbol j+6
//   codeWordOut[59:0]  [4*i +: 4] = symbol i; 0..5 parity, 6..14 message
//   codeWordValid  one-cycle pulse while in DONE
//   encoderBusy    high in SHIFT and DONE
//   selfCheckErr   (only with RS_ENC_SELFCHECK_EN) high in DONE when any of
//                  the syndromes S1..S6 of codeWordOut is nonzero
//
// Handshake: a start is taken on the first rising edge at which the FSM is
// in IDLE and encodeMessage is 1; messageIn is captured on that same edge.
// codeWordOut is valid from the DONE cycle on and holds until the next DONE.
//
// Timing: start edge N clears parity; edges N+1..N+9 shift symbols 14..6
// (counter 0..8); the edge processing counter 8 also loads codeWordOut and
// enters DONE; the following edge returns to IDLE. With encodeMessage held
// high, starts repeat every 11 clocks.
//
// Build option: define RS_ENC_SELFCHECK_EN to add the selfCheckErr output.
// ---------------------------------------------------------------------------
module rs_encoder_seq
    import rs_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    encodeMessage,
    input  logic [K*SYM_W-1:0]      messageIn,
    output logic [N*SYM_W-1:0]      codeWordOut,
    output logic                    codeWordValid,
    output logic                    encoderBusy
`ifdef RS_ENC_SELFCHECK_EN
    ,
    output logic                    selfCheckErr
`endif
);

    enc_state_e                        state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [K*SYM_W-1:0]                msg_q, msg_d;
    logic [NPAR-1:0][SYM_W-1:0]        par_q, par_d;
    logic [N*SYM_W-1:0]                cw_q, cw_d;

    logic [SYM_W-1:0]                  sym;
    logic [SYM_W-1:0]                  fb;
    logic [NPAR-1:0][SYM_W-1:0]        gprod;
    logic [NPAR-1:0][SYM_W-1:0]        par_step;

    // Counter value c selects message symbol 8-c (codeword symbol 14-c).
    always_comb begin
        sym = '0;
        for (int j = 0; j < K; j++) begin
            if (cnt_q == CNT_W'(K - 1 - j)) sym = msg_q[SYM_W*j +: SYM_W];
        end
    end

    assign fb = sym ^ par_q[NPAR-1];

    for (genvar k = 0; k < NPAR; k++) begin : g_mult
        gf_mult u_gf_mult (
            .a_i (GEN_COEF[SYM_W*k +: SYM_W]),
            .b_i (fb),
            .p_o (gprod[k])
        );
    end

    always_comb begin
        par_step[0] = gprod[0];
        for (int k = 1; k < NPAR; k++) begin
            par_step[k] = par_q[k-1] ^ gprod[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        par_d   = par_q;
        cw_d    = cw_q;
        case (state_q)
            ST_IDLE: begin
                if (encodeMessage) begin
                    msg_d   = messageIn;
                    par_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                par_d = par_step;
                cnt_d = cnt_q + CNT_W'(1);
                // Last symbol: the codeword takes the freshly updated parity.
                if (cnt_q == CNT_W'(K - 1)) begin
                    cw_d    = {msg_q, par_step};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            msg_q   <= '0;
            par_q   <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            par_q   <= par_d;
            cw_q    <= cw_d;
        end
    end

    // Status outputs decode straight from the state register so reset
    // clears them without waiting for a clock.
    assign codeWordOut   = cw_q;
    assign codeWordValid = (state_q == ST_DONE);
    assign encoderBusy   = (state_q != ST_IDLE);

`ifdef RS_ENC_SELFCHECK_EN
    logic             syn_nz;
    logic [SYM_W-1:0] syn;

    // S_i = sum_j c_j * alpha^(i*j), i = 1..6; all zero for a valid codeword.
    always_comb begin
        syn_nz = 1'b0;
        syn    = '0;
        for (int i = 1; i <= NPAR; i++) begin
            syn = '0;
            for (int j = 0; j < N; j++) begin
                syn = syn ^ gf_mul(cw_q[SYM_W*j +: SYM_W],
                                   GF_EXP_TBL[SYM_W*((i*j) % N) +: SYM_W]);
            end
            if (syn != '0) syn_nz = 1'b1;
        end
    end

    assign selfCheckErr = (state_q == ST_DONE) && syn_nz;
`endif

endmodule

// File: tb/tb_rs_encoder_seq.sv
// ---------------------------------------------------------------------------
// tb_rs_encoder_seq -- self-checking bench for rs_encoder_seq.
// Expected codewords come from a polynomial long-division model built on
// GF tables generated here; a monitor pops them from exp_q on each
// codeWordValid pulse and also checks that all six syndromes are zero.
// ---------------------------------------------------------------------------
module tb_rs_encoder_seq;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        encodeMessage = 1'b0;
    logic [35:0] messageIn = '0;
    logic [59:0] codeWordOut;
    logic        codeWordValid;
    logic        encoderBusy;
`ifdef RS_ENC_SELFCHECK_EN
    logic        selfCheckErr;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rs_encoder_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .encodeMessage (encodeMessage),
        .messageIn     (messageIn),
        .codeWordOut   (codeWordOut),
        .codeWordValid (codeWordValid),
        .encoderBusy   (encoderBusy)
`ifdef RS_ENC_SELFCHECK_EN
        ,
        .selfCheckErr  (selfCheckErr)
`endif
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    logic [59:0] exp_q[$];
    logic [59:0] obs_q[$];
    int          valid_cyc[$];
    bit          corrupt_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- GF(16) reference model ----------------
    logic [3:0] gexp [0:14];
    int         glog [0:15];
    logic [3:0] gen  [0:6];

    function automatic logic [3:0] tb_mul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    task automatic build_gf();
        logic [3:0] v;
        logic [3:0] r;
        v = 4'h1;
        glog[0] = 0;
        for (int e = 0; e < 15; e++) begin
            gexp[e] = v;
            glog[v] = e;
            v = {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
        end
        gen[0] = 4'h1;
        for (int k = 1; k < 7; k++) gen[k] = 4'h0;
        for (int i = 1; i <= 6; i++) begin
            r = gexp[i];
            for (int k = 6; k >= 1; k--) gen[k] = gen[k-1] ^ tb_mul(gen[k], r);
            gen[0] = tb_mul(gen[0], r);
        end
    endtask

    // Long division of m(x)*x^6 by g(x); remainder forms the parity.
    function automatic logic [59:0] model_encode(input logic [35:0] m);
        logic [3:0]  r [0:14];
        logic [3:0]  c;
        logic [59:0] cw;
        for (int j = 0; j < 15; j++) r[j] = 4'h0;
        for (int j = 0; j < 9; j++) r[j+6] = m[4*j +: 4];
        for (int d = 14; d >= 6; d--) begin
            c = r[d];
            for (int k = 0; k <= 6; k++) r[d-6+k] = r[d-6+k] ^ tb_mul(c, gen[k]);
        end
        cw = '0;
        for (int j = 0; j < 6; j++) cw[4*j +: 4] = r[j];
        cw[59:24] = m;
        return cw;
    endfunction

    function automatic bit syndromes_zero(input logic [59:0] cw);
        logic [3:0] s;
        for (int i = 1; i <= 6; i++) begin
            s = 4'h0;
            for (int j = 0; j < 15; j++) s = s ^ tb_mul(cw[4*j +: 4], gexp[(i*j) % 15]);
            if (s != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [59:0] exp_cw;
    always @(negedge clk) begin
        if (codeWordValid) begin
            valid_cyc.push_back(cyc);
            obs_q.push_back(codeWordOut);
            if (corrupt_mode) begin
`ifdef RS_ENC_SELFCHECK_EN
                check("selfcheck_err_forced", {63'b0, selfCheckErr}, 64'd1);
`endif
            end else if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_cw = exp_q.pop_front();
                check("codeword", {4'h0, codeWordOut}, {4'h0, exp_cw});
                check("syndromes", {63'b0, syndromes_zero(codeWordOut)}, 64'd1);
`ifdef RS_ENC_SELFCHECK_EN
                check("selfcheck_err_clean", {63'b0, selfCheckErr}, 64'd0);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_one(input logic [35:0] m, input logic [59:0] cw);
        int edges;
        bit seen;
        @(negedge clk);
        messageIn     = m;
        encodeMessage = 1'b1;
        exp_q.push_back(cw);
        @(posedge clk);
        edges = 1;
        #1;
        encodeMessage = 1'b0;
        messageIn     = {4'($urandom_range(15, 0)), 32'($urandom)};
        check("busy_after_start", {63'b0, encoderBusy}, 64'd1);
        seen = 1'b0;
        while (!seen && edges < 30) begin
            @(negedge clk);
            if (codeWordValid) begin
                seen = 1'b1;
            end else begin
                // A start request mid-encode must be ignored.
                encodeMessage = (edges == 4);
                messageIn     = {4'($urandom_range(15, 0)), 32'($urandom)};
                @(posedge clk);
                edges++;
            end
        end
        encodeMessage = 1'b0;
        check("latency_edges", 64'(edges), 64'd10);
        @(negedge clk);
        check("busy_after_done", {63'b0, encoderBusy}, 64'd0);
        check("valid_one_cycle", {63'b0, codeWordValid}, 64'd0);
        repeat (3) @(negedge clk);
        check("codeword_hold", {4'h0, codeWordOut}, {4'h0, cw});
    endtask

    typedef struct {
        logic [35:0] msg;
        logic [59:0] cw;
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        logic [35:0] a, b, m;
        build_gf();

        // Reset state
        #1;
        check("rst_cw", {4'h0, codeWordOut}, 64'd0);
        check("rst_valid", {63'b0, codeWordValid}, 64'd0);
        check("rst_busy", {63'b0, encoderBusy}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Table of vectors
        vecs[0] = '{msg: 36'h000000000, cw: 60'h0};
        vecs[1] = '{msg: 36'h000000001, cw: {36'h000000001, 24'h793CAC}};
        vecs[2] = '{msg: 36'h123456789, cw: model_encode(36'h123456789)};
        for (int i = 3; i < 6; i++) begin
            m = {4'($urandom_range(15, 0)), 32'($urandom)};
            vecs[i] = '{msg: m, cw: model_encode(m)};
        end
        for (int i = 0; i < 6; i++) run_one(vecs[i].msg, vecs[i].cw);

        // Back-to-back: request held high, message swapped between starts.
        a = 36'hABCDEF012;
        b = 36'h00F00F00F;
        obs_q.delete();
        valid_cyc.delete();
        @(negedge clk);
        messageIn     = a;
        encodeMessage = 1'b1;
        exp_q.push_back(model_encode(a));
        exp_q.push_back(model_encode(b));
        exp_q.push_back(model_encode(a ^ b));
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 messageIn = b;
        repeat (11) @(posedge clk);
        #1 messageIn = a ^ b;
        repeat (6) @(posedge clk);
        #1 encodeMessage = 1'b0;
        for (int i = 0; i < 40 && obs_q.size() < 3; i++) @(negedge clk);
        check("b2b_count", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() >= 3) begin
            check("b2b_spacing_1", 64'(valid_cyc[1] - valid_cyc[0]), 64'd11);
            check("b2b_spacing_2", 64'(valid_cyc[2] - valid_cyc[1]), 64'd11);
            check("b2b_linearity", {4'h0, obs_q[2]}, {4'h0, obs_q[0] ^ obs_q[1]});
        end
        exp_q.delete();

        // Abort mid-SHIFT with reset; nothing is queued, so any valid fails.
        @(negedge clk);
        messageIn     = 36'h5A5A5A5A5;
        encodeMessage = 1'b1;
        @(posedge clk);
        #1 encodeMessage = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cw", {4'h0, codeWordOut}, 64'd0);
        check("abort_valid", {63'b0, codeWordValid}, 64'd0);
        check("abort_busy", {63'b0, encoderBusy}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        run_one(36'h5A5A5A5A5, model_encode(36'h5A5A5A5A5));

`ifdef RS_ENC_SELFCHECK_EN
        // Corrupted parity register must raise selfCheckErr in DONE.
        obs_q.delete();
        corrupt_mode = 1'b1;
        force dut.par_q = 24'h000001;
        @(negedge clk);
        messageIn     = 36'h0;
        encodeMessage = 1'b1;
        @(posedge clk);
        #1 encodeMessage = 1'b0;
        for (int i = 0; i < 30 && obs_q.size() < 1; i++) @(negedge clk);
        check("forced_done_seen", 64'(obs_q.size()), 64'd1);
        @(negedge clk);
        release dut.par_q;
        corrupt_mode = 1'b0;
        run_one(36'h0C0FFEE42, model_encode(36'h0C0FFEE42));
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
